// File: rtl/uart_rx_axis_if.sv
// AXI4-Stream byte channel carrying received UART characters.
interface uart_rx_axis_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_axis.sv
// 8N1-style UART receiver: prescale*8 clocks per bit, mid-bit sampling,
// received characters presented on an AXI4-Stream master with overrun/framing pulses.
module uart_rx_axis #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_axis_if.master       m_axis,
    input  logic                 rxd,
    output logic                 busy,
    output logic                 overrun_error,
    output logic                 frame_error,
    input  logic [31:0]          prescale
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                r_state;
    logic                  r_rxd_m;
    logic                  r_rxd_s;
    logic                  r_armed;
    logic [28:0]           r_p;
    logic [31:0]           r_cnt;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_busy;
    logic                  r_ovr;
    logic                  r_ferr;

    logic [28:0]           w_p_in;
    logic [31:0]           w_half_in;
    logic [31:0]           w_full;
    logic                  w_unused_prescale_hi;

    // A prescale of zero behaves as one; the top three bits carry no meaning.
    assign w_p_in               = (prescale[28:0] == 29'd0) ? 29'd1 : prescale[28:0];
    assign w_half_in            = {1'b0, w_p_in, 2'b00} - 32'd1;
    assign w_full               = {r_p, 3'b000} - 32'd1;
    assign w_unused_prescale_hi = ^prescale[31:29];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_m  <= 1'b1;
            r_rxd_s  <= 1'b1;
            r_armed  <= 1'b1;
            r_state  <= IDLE;
            r_cnt    <= 32'd0;
            r_bit    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_ovr    <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_rxd_m <= rxd;
            r_rxd_s <= r_rxd_m;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
            if (r_tvalid && m_axis.tready)
                r_tvalid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_rxd_s)
                        r_armed <= 1'b1;
                    // Counter reaches zero exactly half a bit after the falling edge.
                    if (r_armed && !r_rxd_s) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                        r_p     <= w_p_in;
                        r_cnt   <= w_half_in;
                    end
                end
                START: begin
                    if (r_cnt == 32'd0) begin
                        if (r_rxd_s) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= DATA;
                            r_cnt   <= w_full;
                            r_bit   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                DATA: begin
                    if (r_cnt == 32'd0) begin
                        r_shift <= {r_rxd_s, r_shift[DATA_WIDTH-1:1]};
                        r_cnt   <= w_full;
                        if (r_bit == BW'(DATA_WIDTH - 1))
                            r_state <= STOP;
                        else
                            r_bit <= r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                STOP: begin
                    if (r_cnt == 32'd0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        // A low stop bit leaves us disarmed until the line idles high (break).
                        r_armed <= r_rxd_s;
                        if (r_rxd_s) begin
                            r_tdata  <= r_shift;
                            r_tvalid <= 1'b1;
                            r_ovr    <= r_tvalid && !m_axis.tready;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign busy          = r_busy;
    assign overrun_error = r_ovr;
    assign frame_error   = r_ferr;
endmodule

// File: tb/tb_uart_rx_axis.sv
// Bench for uart_rx_axis: a vector table of single frames, hand-written corner
// sequences, and randomized frames checked against a queue-based model.
module tb_uart_rx_axis;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [31:0] prescale = 32'd1;
    logic        busy, overrun_error, frame_error;

    uart_rx_axis_if #(.DATA_WIDTH(8)) axis ();

    uart_rx_axis #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .m_axis(axis), .rxd(rxd), .busy(busy),
        .overrun_error(overrun_error), .frame_error(frame_error), .prescale(prescale)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor-owned state; tests only read snapshots of it.
    int         cyc = 0;
    logic [7:0] beat_mem [0:1023];
    int         beat_n = 0;
    int         ferr_cnt = 0, ovr_cnt = 0, busy_cnt = 0, tv_cnt = 0, both_cnt = 0;
    int         tv_rise_cyc = 0;
    logic       prev_tv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (axis.tvalid && axis.tready) begin
                beat_mem[beat_n[9:0]] = axis.tdata;
                beat_n = beat_n + 1;
            end
            if (frame_error) ferr_cnt = ferr_cnt + 1;
            if (overrun_error) ovr_cnt = ovr_cnt + 1;
            if (frame_error && overrun_error) both_cnt = both_cnt + 1;
            if (busy) busy_cnt = busy_cnt + 1;
            if (axis.tvalid) tv_cnt = tv_cnt + 1;
            if (axis.tvalid && !prev_tv) tv_rise_cyc = cyc;
        end
        prev_tv = axis.tvalid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bitw(input logic v, input int pp);
        rxd = v;
        repeat (8 * pp) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input int pr);
        int pp;
        pp = (pr == 0) ? 1 : pr;
        prescale = pr;
        bitw(1'b0, pp);
        for (int i = 0; i < 8; i++) bitw(d[i], pp);
        bitw(stop, pp);
        rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        int         p;
        bit         stop;
        int         exp_beats;
        logic [7:0] exp_d;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int b0, f0, o0, bz0, tv0, c0, pp;
        logic [7:0] exp_q [$];
        int exp_ferr;
        logic [7:0] d;
        bit st;

        vecs[0] = '{8'h55, 1, 1'b1, 1, 8'h55, 0};
        vecs[1] = '{8'hA5, 2, 1'b1, 1, 8'hA5, 0};
        vecs[2] = '{8'h3C, 1, 1'b0, 0, 8'h00, 1};
        vecs[3] = '{8'hC3, 0, 1'b1, 1, 8'hC3, 0};
        vecs[4] = '{8'h81, 3, 1'b1, 1, 8'h81, 0};
        vecs[5] = '{8'h00, 1, 1'b1, 1, 8'h00, 0};
        vecs[6] = '{8'hFF, 1, 1'b0, 0, 8'h00, 1};

        axis.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
        chk("rst_tdata", {24'd0, axis.tdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_errs", {30'd0, overrun_error, frame_error}, 32'd0);
        rst = 1'b0;
        idle(4);

        // Exact latency of a basic 0x55 frame at prescale 1.
        b0 = beat_n; bz0 = busy_cnt; tv0 = tv_cnt; c0 = cyc;
        send_frame(8'h55, 1'b1, 1);
        idle(10);
        chk("basic_latency", tv_rise_cyc - c0, 32'd79);
        chk("basic_busy_len", busy_cnt - bz0, 32'd76);
        chk("basic_tvalid_len", tv_cnt - tv0, 32'd1);
        chk("basic_beats", beat_n - b0, 32'd1);
        chk("basic_data", {24'd0, beat_mem[b0[9:0]]}, 32'h55);

        foreach (vecs[i]) begin
            b0 = beat_n; f0 = ferr_cnt; o0 = ovr_cnt;
            send_frame(vecs[i].d, vecs[i].stop, vecs[i].p);
            idle(24);
            chk($sformatf("vec%0d_beats", i), beat_n - b0, vecs[i].exp_beats);
            if (vecs[i].exp_beats == 1)
                chk($sformatf("vec%0d_data", i), {24'd0, beat_mem[b0[9:0]]}, {24'd0, vecs[i].exp_d});
            chk($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            chk($sformatf("vec%0d_ovr", i), ovr_cnt - o0, 32'd0);
        end

        // Back-to-back frames at prescale 2.
        b0 = beat_n; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h00, 1'b1, 2);
        send_frame(8'hFF, 1'b1, 2);
        send_frame(8'hA5, 1'b1, 2);
        idle(30);
        chk("b2b_beats", beat_n - b0, 32'd3);
        chk("b2b_d0", {24'd0, beat_mem[b0[9:0]]}, 32'h00);
        chk("b2b_d1", {24'd0, beat_mem[(b0 + 1) % 1024]}, 32'hFF);
        chk("b2b_d2", {24'd0, beat_mem[(b0 + 2) % 1024]}, 32'hA5);
        chk("b2b_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);

        // Overrun under backpressure.
        axis.tready = 1'b0;
        b0 = beat_n; o0 = ovr_cnt;
        send_frame(8'h12, 1'b1, 1);
        send_frame(8'h34, 1'b1, 1);
        idle(10);
        chk("ovr_tdata", {24'd0, axis.tdata}, 32'h34);
        chk("ovr_tvalid", {31'd0, axis.tvalid}, 32'd1);
        chk("ovr_pulses", ovr_cnt - o0, 32'd1);
        chk("ovr_no_beats", beat_n - b0, 32'd0);
        axis.tready = 1'b1;
        @(posedge clk);
        #1;
        chk("ovr_drain_tvalid", {31'd0, axis.tvalid}, 32'd0);
        chk("ovr_drain_beats", beat_n - b0, 32'd1);
        chk("ovr_drain_data", {24'd0, beat_mem[b0[9:0]]}, 32'h34);

        // Break: line held low for 50 bit times.
        b0 = beat_n; f0 = ferr_cnt;
        rxd = 1'b0;
        repeat (50 * 8) @(posedge clk);
        #1;
        idle(32);
        chk("break_ferr", ferr_cnt - f0, 32'd1);
        chk("break_beats", beat_n - b0, 32'd0);
        send_frame(8'h81, 1'b1, 1);
        idle(16);
        chk("break_after_beats", beat_n - b0, 32'd1);
        chk("break_after_data", {24'd0, beat_mem[b0[9:0]]}, 32'h81);

        // Two-cycle glitch must be rejected at the start-bit sample.
        prescale = 32'd1;
        b0 = beat_n; f0 = ferr_cnt; bz0 = busy_cnt;
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(12);
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        chk("glitch_busy_len", busy_cnt - bz0, 32'd4);
        chk("glitch_beats", beat_n - b0, 32'd0);
        chk("glitch_ferr", ferr_cnt - f0, 32'd0);

        // Reset in the middle of bit 3 of 0x99, with a stale byte pending.
        axis.tready = 1'b0;
        send_frame(8'h5A, 1'b1, 1);
        idle(4);
        chk("pre_rst_tvalid", {31'd0, axis.tvalid}, 32'd1);
        bitw(1'b0, 1);
        bitw(1'b1, 1);
        bitw(1'b0, 1);
        bitw(1'b0, 1);
        rxd = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tvalid", {31'd0, axis.tvalid}, 32'd0);
        chk("midrst_tdata", {24'd0, axis.tdata}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_errs", {30'd0, overrun_error, frame_error}, 32'd0);
        rst = 1'b0;
        axis.tready = 1'b1;
        idle(16);
        b0 = beat_n; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h66, 1'b1, 1);
        idle(16);
        chk("postrst_beats", beat_n - b0, 32'd1);
        chk("postrst_data", {24'd0, beat_mem[b0[9:0]]}, 32'h66);
        chk("postrst_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);

        // Randomized frames: the model is simply the ordered list of good
        // characters plus a count of frames sent with a low stop bit.
        b0 = beat_n; f0 = ferr_cnt; o0 = ovr_cnt;
        exp_ferr = 0;
        for (int k = 0; k < 24; k++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 4) != 0);
            pp = $urandom_range(0, 3);
            send_frame(d, st, pp);
            if (st) exp_q.push_back(d);
            else exp_ferr++;
            idle(st ? $urandom_range(0, 15) : 8 * ((pp == 0) ? 1 : pp) + 4);
        end
        idle(40);
        chk("rand_beats", beat_n - b0, exp_q.size());
        foreach (exp_q[i])
            if (i < beat_n - b0)
                chk($sformatf("rand_data%0d", i), {24'd0, beat_mem[(b0 + i) % 1024]}, {24'd0, exp_q[i]});
        chk("rand_ferr", ferr_cnt - f0, exp_ferr);
        chk("rand_ovr", ovr_cnt - o0, 32'd0);
        chk("err_exclusive", both_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_axis.md
Name: uart_rx_axis

Overview:
- UART receiver with an AXI4-Stream master output. It is the receive-direction counterpart of the team's AXI-Stream UART transmitter.
- Deserialises 8N1-style frames from the rxd pin and presents each byte on m_axis.
- Uses the same prescale convention as the transmitter: bit period = prescale*8 clk cycles. It sits between the board RX pin and the UART-lite register/FIFO logic.

Parameters:
- DATA_WIDTH, 8, data bits per frame, LSB first; legal range 5..9.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- m_axis_tdata  output  DATA_WIDTH  received byte.
- m_axis_tvalid  output  1  byte available.
- m_axis_tready  input  1  consumer accepts byte.
- rxd  input  1  asynchronous serial input, idle high.
- busy  output  1  frame reception in progress.
- overrun_error  output  1  one-cycle pulse: byte lost to an unread previous byte.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- prescale  input  32  clk cycles per bit / 8. Values of 0 are treated as 1. Only bits [28:0] are significant.

Behaviour:
- Reset: clk and rst are as decided: reset rst, synchronous, active-high; clock clk.
  - Reset values: m_axis_tvalid=0, m_axis_tdata=0, busy=0, overrun_error=0, frame_error=0.
  - Synchronizer flops=1, state=IDLE, counters=0.
  - Reset mid-frame abandons the frame with no error pulse.
- Input sync: rxd passes through 2 flops; rxd_s is the second flop. All decisions use rxd_s, giving 2 cycles of pin-to-rxd_s latency.
- Prescale handling: latched as p at start detection. A prescale change mid-frame has no effect until the next frame.
- States: IDLE, START, DATA, STOP. A 32-bit down-counter gives the sample timing and a bit counter counts DATA_WIDTH bits. Let D = first cycle in IDLE with rxd_s==0.
- IDLE -> START at D; busy=1 from D+1. Counter loaded so that the start bit is sampled at D+4p (mid-bit).
- START, at D+4p:
  - rxd_s==0 -> DATA.
  - rxd_s==1 -> IDLE. This is glitch rejection: no error pulse, busy drops next cycle.
- DATA: bit i (i=0..DATA_WIDTH-1) is sampled at D+4p+8p*(i+1) and shifted in LSB first. After the last bit -> STOP.
- STOP: stop bit sampled at D+4p+8p*(DATA_WIDTH+1). Then -> IDLE, busy=0 next cycle.
  - rxd_s==1: in the next cycle, m_axis_tdata=shift register and m_axis_tvalid=1.
  - rxd_s==0: in the next cycle, frame_error=1 for exactly one cycle. The byte is discarded and tvalid/tdata are unchanged.
  - On returning to IDLE, a new start is not detected until rxd_s has been seen high at least once. A held-low line (break) therefore produces a single frame_error, not repeated frames.
- Output handshake:
  - m_axis_tvalid stays high until a cycle with tvalid&&tready, then clears next cycle.
  - tdata is stable while tvalid=1 unless an overrun occurs.
- Overrun: a good byte completes while tvalid=1 and tready=0 in that same cycle.
  - The new byte overwrites tdata, tvalid stays 1, and overrun_error pulses one cycle.
  - If tready=1 in that same cycle, the old byte counts as accepted: no overrun, and the new byte is presented.
- Reception continues regardless of tvalid; there is no backpressure to the line.
- Error pulses are independent. frame_error and overrun_error are never asserted in the same cycle.

Test Plan:
- Basic byte: prescale=1, tready=1, send 0x55 (8N1) -> stop sampled at D+76, tvalid=1 with tdata=0x55 at D+77 for one cycle. busy high D+1..D+76.
- Back-to-back: prescale=2, send 0x00,0xFF,0xA5 with no idle gap, tready=1 -> three beats 0x00,0xFF,0xA5 in order, no error pulses.
- Backpressure/overrun: prescale=1, tready=0, send 0x12 then 0x34 -> after frame 2, tdata=0x34, overrun_error one-cycle pulse, tvalid still 1. Raising tready -> one beat 0x34, then tvalid=0.
- Framing error and break:
  - send 0x3C with stop bit=0 -> frame_error one pulse, tvalid stays 0.
  - hold rxd low 50 bit times -> exactly one frame_error; then rxd high and send 0x81 -> tdata=0x81.
- Glitch and prescale=0: prescale=1, 2-cycle low pulse on rxd -> no tvalid, no error, busy returns low by D+5. prescale=0, send 0xC3 -> received as with prescale=1.
- Reset mid-frame: assert rst during bit 3 of 0x99 -> all outputs 0 next cycle. After release, send 0x66 -> tdata=0x66, no errors.
